// File: rtl/apb_mac_design.sv
// apb_mac_design: APB register block around a radix-2 Booth multiplier
// with a 32-bit signed accumulator.
// Optional build macro ACC_SATURATE_EN: when defined the accumulator clamps
// at 32'h7FFF_FFFF / 32'h8000_0000 on signed overflow; otherwise it wraps.
module apb_mac_design #(
  parameter int          OPERAND_WIDTH = 8,
  parameter logic [31:0] SLAVE_BASE    = 32'h0000_0000
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSELx,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [31:0]                  PADDR,
  input  logic [31:0]                  PWDATA,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [2*OPERAND_WIDTH-1:0]   BOOTH_OUTPUT,
  output logic                         BOOTH_READY
);

  localparam int W     = OPERAND_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  localparam logic [2:0] IDX_OPA    = 3'd0;
  localparam logic [2:0] IDX_OPB    = 3'd1;
  localparam logic [2:0] IDX_CTRL   = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_PROD   = 3'd4;
  localparam logic [2:0] IDX_ACC    = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Programmer-visible registers
  logic [W-1:0]     r_opa;
  logic [W-1:0]     r_opb;
  logic             r_acc_en;
  logic             r_done;
  logic [2*W-1:0]   r_product;
  logic [31:0]      r_acc;

  // Booth working registers: A and M carry one extra bit so that the most
  // negative multiplicand can be negated without overflow.
  logic [W:0]       r_a;
  logic [W-1:0]     r_q;
  logic             r_qm1;
  logic [W:0]       r_m;
  logic [CNT_W-1:0] r_count;

  // Address decode and transfer qualification
  logic        w_access;
  logic [31:0] w_offset;
  logic        w_mapped;
  logic [2:0]  w_idx;
  logic        w_is_opa;
  logic        w_is_opb;
  logic        w_is_ctrl;
  logic        w_is_ro;
  logic        w_busy;
  logic        w_busy_block;
  logic        w_err;
  logic        w_wr_ok;
  logic        w_wr_opa;
  logic        w_wr_opb;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_acc_clr;
  logic        w_finish;

  // Booth step and accumulation datapath
  logic [W:0]       w_sum;
  logic [W:0]       w_a_next;
  logic [W-1:0]     w_q_next;
  logic [2*W-1:0]   w_prod_next;
  logic [31:0]      w_prod_next_32;
  logic [31:0]      w_prod_32;
  logic [32:0]      w_acc_wide;
  logic             w_acc_ovf;
  logic [31:0]      w_acc_new;
  logic [31:0]      w_opa_32;
  logic [31:0]      w_opb_32;
  logic             w_unused_pwdata;

  assign w_access  = PSELx & PENABLE;
  assign w_offset  = PADDR - SLAVE_BASE;
  assign w_mapped  = (w_offset[1:0] == 2'b00) && (w_offset < 32'h18);
  assign w_idx     = w_offset[4:2];
  assign w_is_opa  = w_mapped && (w_idx == IDX_OPA);
  assign w_is_opb  = w_mapped && (w_idx == IDX_OPB);
  assign w_is_ctrl = w_mapped && (w_idx == IDX_CTRL);
  assign w_is_ro   = w_mapped && ((w_idx == IDX_STATUS) || (w_idx == IDX_PROD) ||
                                  (w_idx == IDX_ACC));
  assign w_busy    = (r_state == ST_CALC);

  // Operands and a restart must not change under a running multiply.
  assign w_busy_block = w_busy && (w_is_opa || w_is_opb || (w_is_ctrl && PWDATA[0]));
  assign w_err        = w_access && (!w_mapped || (PWRITE && (w_is_ro || w_busy_block)));
  assign w_wr_ok      = w_access && PWRITE && !w_err;
  assign w_wr_opa     = w_wr_ok && w_is_opa;
  assign w_wr_opb     = w_wr_ok && w_is_opb;
  assign w_wr_ctrl    = w_wr_ok && w_is_ctrl;
  assign w_start      = w_wr_ctrl && PWDATA[0];
  assign w_acc_clr    = w_wr_ctrl && PWDATA[1];
  assign w_finish     = w_busy && (r_count == LAST_CNT);

  assign w_unused_pwdata = ^PWDATA[31:W];

  // Next-state logic: one START launches exactly W CALC cycles
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_state_next = ST_CALC;
      ST_CALC: if (w_finish) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // One Booth step: add/subtract/none chosen by (Q0, Q-1)
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic shift right of {A, Q}; the low 2W bits form the product
  assign w_a_next    = {w_sum[W], w_sum[W:1]};
  assign w_q_next    = {w_sum[0], r_q[W-1:1]};
  assign w_prod_next = {w_a_next[W-1:0], w_q_next};

  assign w_prod_next_32 = 32'($signed(w_prod_next));
  assign w_prod_32      = 32'($signed(r_product));
  assign w_opa_32       = 32'($signed(r_opa));
  assign w_opb_32       = 32'($signed(r_opb));

  // 33-bit sum exposes signed overflow as a disagreement of the top two bits
  assign w_acc_wide = {r_acc[31], r_acc} + {w_prod_next_32[31], w_prod_next_32};
  assign w_acc_ovf  = w_acc_wide[32] ^ w_acc_wide[31];
`ifdef ACC_SATURATE_EN
  assign w_acc_new  = w_acc_ovf ? (w_acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                : w_acc_wide[31:0];
`else
  assign w_acc_new  = w_acc_wide[31:0];
`endif

  // Booth working registers: load on START, step once per CALC cycle
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_a     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_a     <= '0;
      r_q     <= r_opb;
      r_qm1   <= 1'b0;
      r_m     <= {r_opa[W-1], r_opa};
      r_count <= '0;
    end else if (w_busy) begin
      r_a     <= w_a_next;
      r_q     <= w_q_next;
      r_qm1   <= r_q[0];
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Product and DONE: cleared by START, captured on the last CALC edge
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else if (w_start) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else if (w_finish) begin
      r_product <= w_prod_next;
      r_done    <= 1'b1;
    end
  end

  // Operand and ACC_EN registers written over APB
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc_en <= 1'b0;
    end else begin
      if (w_wr_opa)  r_opa    <= PWDATA[W-1:0];
      if (w_wr_opb)  r_opb    <= PWDATA[W-1:0];
      if (w_wr_ctrl) r_acc_en <= PWDATA[2];
    end
  end

  // Accumulator: a clear takes priority over a coincident completion
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_acc <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
    end else if (w_finish && r_acc_en) begin
      r_acc <= w_acc_new;
    end
  end

  // Read mux: only drives data during a read access phase
  always_comb begin
    PRDATA = 32'h0;
    if (w_access && !PWRITE && w_mapped) begin
      case (w_idx)
        IDX_OPA:    PRDATA = w_opa_32;
        IDX_OPB:    PRDATA = w_opb_32;
        IDX_CTRL:   PRDATA = 32'h0;
        IDX_STATUS: PRDATA = {29'h0, r_acc_en, r_done, w_busy};
        IDX_PROD:   PRDATA = w_prod_32;
        IDX_ACC:    PRDATA = r_acc;
        default:    PRDATA = 32'h0;
      endcase
    end
  end

  assign PREADY       = w_access;
  assign PSLVERR      = w_err;
  assign BOOTH_OUTPUT = r_product;
  assign BOOTH_READY  = ~w_busy;

endmodule

// File: tb/tb_apb_mac_design.sv
// Self-checking bench for apb_mac_design: an 8-bit instance at base 0 and a
// 16-bit instance at 0x4000_0000 (used for accumulator overflow), sharing
// the APB bus with separate selects. Expected values come from plain
// signed arithmetic on the operands.
module tb_apb_mac_design;

  localparam logic [31:0] BASE16 = 32'h4000_0000;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        PRESETn, PENABLE, PWRITE, sel8, sel16;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] prdata8, prdata16;
  logic        pready8, pready16, pslverr8, pslverr16, bready8, bready16;
  logic [15:0] bout8;
  logic [31:0] bout16;

  bit          use16 = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_acc = 32'h0;
  bit          m_en  = 1'b0;
  longint      m_pa, m_pb;

  logic        t_ready;
  logic [31:0] t_bout;
  assign t_ready = use16 ? bready16 : bready8;
  assign t_bout  = use16 ? bout16 : {16'h0, bout8};

  apb_mac_design #(.OPERAND_WIDTH(8), .SLAVE_BASE(32'h0000_0000)) u_dut8 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(sel8), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata8),
    .PREADY(pready8), .PSLVERR(pslverr8), .BOOTH_OUTPUT(bout8),
    .BOOTH_READY(bready8)
  );

  apb_mac_design #(.OPERAND_WIDTH(16), .SLAVE_BASE(BASE16)) u_dut16 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(sel16), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata16),
    .PREADY(pready16), .PSLVERR(pslverr16), .BOOTH_OUTPUT(bout16),
    .BOOTH_READY(bready16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference accumulation: exact signed sum, then clamp or wrap to 32 bits
  function automatic logic [31:0] acc_add(input logic [31:0] acc, input longint p);
    longint s;
    s = longint'($signed(acc)) + p;
`ifdef ACC_SATURATE_EN
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
`endif
    return s[31:0];
  endfunction

  // One full APB transfer; samples response during the access phase
  task automatic apb(input bit wr, input logic [31:0] off, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(posedge PCLK); #1;
    sel8    = ~use16;
    sel16   = use16;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = (use16 ? BASE16 : 32'h0) + off;
    PWDATA  = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    rdata = use16 ? prdata16 : prdata8;
    err   = use16 ? pslverr16 : pslverr8;
    chk("pready", {63'h0, (use16 ? pready16 : pready8)}, 64'd1);
    @(posedge PCLK); #1;
    sel8 = 1'b0; sel16 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("[TB] %s w%0d addr=%08h wdata=%08h rdata=%08h err=%0b",
             wr ? "WR" : "RD", use16 ? 16 : 8, PADDR, wdata, rdata, err);
  endtask

  task automatic wr_reg(input string tag, input logic [31:0] off, input logic [31:0] d,
                        input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(1'b1, off, d, rd, er);
    chk(tag, {63'h0, er}, {63'h0, exp_err});
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] off, input logic [31:0] exp_d,
                        input logic exp_err);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, off, 32'h0, rd, er);
    chk(tag, {32'h0, rd}, {32'h0, exp_d});
    chk({tag, "_err"}, {63'h0, er}, {63'h0, exp_err});
  endtask

  // Load operands and START (keeping the model's ACC_EN); ACC_CLR optional
  task automatic start_mul(input longint a, input longint b, input bit clr);
    m_pa = a;
    m_pb = b;
    wr_reg("wr_opa", 32'h00, a[31:0], 1'b0);
    wr_reg("wr_opb", 32'h04, b[31:0], 1'b0);
    wr_reg("wr_start", 32'h08, {29'h0, m_en, clr, 1'b1}, 1'b0);
    if (clr) m_acc = 32'h0;
    chk("busy_after_start", {63'h0, t_ready}, 64'd0);
  endtask

  // Wait (bounded) for BOOTH_READY, then check product and accumulator
  task automatic finish_mul(input bit check_lat);
    int     lat;
    int     w;
    longint p;
    lat = 1;
    w   = use16 ? 16 : 8;
    while (!t_ready && lat < 64) begin
      @(posedge PCLK); #1;
      lat++;
    end
    chk("ready_bound", {63'h0, t_ready}, 64'd1);
    if (check_lat) chk("latency", 64'(lat), 64'(w + 1));
    p = m_pa * m_pb;
    if (m_en) m_acc = acc_add(m_acc, p);
    chk("booth_out", {32'h0, t_bout}, use16 ? {32'h0, p[31:0]} : {48'h0, p[15:0]});
    rd_reg("rd_product", 32'h10, p[31:0], 1'b0);
    rd_reg("rd_acc", 32'h14, m_acc, 1'b0);
  endtask

  task automatic do_mul(input longint a, input longint b);
    start_mul(a, b, 1'b0);
    finish_mul(1'b1);
  endtask

  initial begin
    longint a, b;
    PRESETn = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sel8 = 1'b0; sel16 = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #1;

    // Reset state
    chk("rst_ready8", {63'h0, bready8}, 64'd1);
    chk("rst_ready16", {63'h0, bready16}, 64'd1);
    chk("rst_bout8", {48'h0, bout8}, 64'd0);
    chk("rst_pready", {63'h0, pready8}, 64'd0);
    chk("rst_pslverr", {63'h0, pslverr8}, 64'd0);
    chk("rst_prdata", {32'h0, prdata8}, 64'd0);
    for (int i = 0; i < 6; i++) rd_reg("rst_reg", 32'(i * 4), 32'h0, 1'b0);

    // ACC_EN + ACC_CLR, then 3*4 and -5*6
    m_en = 1'b1;
    wr_reg("wr_ctrl", 32'h08, 32'h6, 1'b0);
    m_acc = 32'h0;
    do_mul(3, 4);
    chk("acc_12", {32'h0, m_acc}, 64'd12);
    do_mul(-5, 6);
    rd_reg("status_done", 32'h0C, 32'h6, 1'b0);

    // Read mid-CALC does not disturb the multiply
    start_mul(2, 3, 1'b0);
    rd_reg("status_busy", 32'h0C, 32'h5, 1'b0);
    finish_mul(1'b0);

    // Writes blocked while busy
    start_mul(10, -7, 1'b0);
    wr_reg("busy_wr_opa", 32'h00, 32'd99, 1'b1);
    wr_reg("busy_wr_start", 32'h08, 32'h5, 1'b1);
    finish_mul(1'b0);
    rd_reg("opa_kept", 32'h00, 32'd10, 1'b0);
    rd_reg("opb_kept", 32'h04, 32'hFFFF_FFF9, 1'b0);

    // Error accesses while idle
    wr_reg("wr_status", 32'h0C, 32'h7, 1'b1);
    wr_reg("wr_product", 32'h10, 32'h1, 1'b1);
    wr_reg("wr_acc", 32'h14, 32'h1, 1'b1);
    rd_reg("rd_unmapped", 32'h18, 32'h0, 1'b1);
    rd_reg("rd_misalign", 32'h02, 32'h0, 1'b1);
    wr_reg("wr_misalign", 32'h01, 32'h55, 1'b1);
    rd_reg("rd_ctrl", 32'h08, 32'h0, 1'b0);
    rd_reg("acc_after_err", 32'h14, m_acc, 1'b0);
    rd_reg("opa_after_err", 32'h00, 32'd10, 1'b0);

    // Boundary operands
    do_mul(-128, -128);
    do_mul(127, -128);
    do_mul(-1, -1);
    do_mul(127, 127);
    do_mul(0, -128);
    do_mul(-128, 1);

    // Random operand pairs
    for (int n = 0; n < 300; n++) begin
      a = longint'($urandom_range(255)) - 128;
      b = longint'($urandom_range(255)) - 128;
      do_mul(a, b);
    end

    // ACC_CLR on the same edge as completion: clear wins
    start_mul(20, 30, 1'b0);
    repeat (5) @(posedge PCLK);
    wr_reg("clr_at_done", 32'h08, 32'h6, 1'b0);
    m_acc = 32'h0;
    chk("clr_ready", {63'h0, t_ready}, 64'd1);
    chk("clr_bout", {32'h0, t_bout}, 64'd600);
    rd_reg("clr_acc", 32'h14, 32'h0, 1'b0);
    rd_reg("clr_status", 32'h0C, 32'h6, 1'b0);

    // ACC_CLR with START: clear first, then accumulate
    start_mul(-3, -3, 1'b1);
    finish_mul(1'b1);

    // ACC_EN off: ACC holds
    m_en = 1'b0;
    wr_reg("ctrl_en_off", 32'h08, 32'h0, 1'b0);
    do_mul(5, 5);

    // Reset during CALC
    m_en = 1'b1;
    wr_reg("ctrl_en_on", 32'h08, 32'h4, 1'b0);
    start_mul(7, 7, 1'b0);
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    #1;
    m_acc = 32'h0;
    m_en  = 1'b0;
    chk("mid_rst_ready", {63'h0, t_ready}, 64'd1);
    chk("mid_rst_bout", {32'h0, t_bout}, 64'd0);
    rd_reg("mid_rst_status", 32'h0C, 32'h0, 1'b0);
    rd_reg("mid_rst_acc", 32'h14, 32'h0, 1'b0);
    rd_reg("mid_rst_opa", 32'h00, 32'h0, 1'b0);

    // 16-bit instance: accumulator overflow behaviour
    use16 = 1'b1;
    rd_reg("w16_rst_acc", 32'h14, 32'h0, 1'b0);
    m_en = 1'b1;
    wr_reg("w16_ctrl", 32'h08, 32'h6, 1'b0);
    m_acc = 32'h0;
    do_mul(-32768, -32768);
    for (int n = 0; n < 4; n++) do_mul(32767, 32767);
    wr_reg("w16_clr", 32'h08, 32'h6, 1'b0);
    m_acc = 32'h0;
    for (int n = 0; n < 4; n++) do_mul(-32768, 32767);
    use16 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
